// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Multi-cycle data-memory responder for the CPU M stage. It accepts one
// load/store request at a time over a valid/ready handshake, waits
// WAIT_STATES cycles, then gives a one-cycle response. While a request is
// being served, stall holds the upstream pipeline registers.
//
// Storage is a little-endian, byte-addressed array of DEPTH_WORDS 16-bit
// words. Address bits above the word index are ignored, so addresses wrap
// modulo 2*DEPTH_WORDS.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   req_valid  in   request present (sampled only while idle)
//   req_write  in   1 = store, 0 = load
//   req_byte   in   1 = byte access, 0 = word access
//   req_addr   in   16-bit byte address
//   req_wdata  in   store data (byte store uses [7:0])
//   req_ready  out  responder can accept a request this cycle
//   rsp_valid  out  one-cycle pulse: access complete
//   rsp_rdata  out  load data, held between responses
//   rsp_err    out  misaligned word access, valid with rsp_valid
//   stall      out  freeze PC/IFID/IDEX/EXM while the access is pending
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        stall
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [3:0]    r_cnt;

  // Request latched on the accepting edge; req_* are ignored afterwards.
  logic          r_write;
  logic          r_byte;
  logic [15:0]   r_addr;
  logic [15:0]   r_wdata;

  logic [15:0]   r_mem [DEPTH_WORDS];
  logic [15:0]   r_rdata;

  logic [AW-1:0] w_idx;
  logic          w_lane;
  logic          w_misaligned;
  logic [15:0]   w_word;
  logic [15:0]   w_load;
  logic          w_in_resp;
  logic          w_accept;

  assign w_idx        = r_addr[AW:1];
  assign w_lane       = r_addr[0];
  assign w_misaligned = !r_byte && r_addr[0];
  assign w_word       = r_mem[w_idx];
  assign w_in_resp    = (r_state == S_RESP);
  assign w_accept     = (r_state == S_IDLE) && req_valid;

  // Read data is formed straight from the array in RESP, so a load that
  // follows a store to the same word sees the freshly committed value.
  always_comb begin
    if (w_misaligned)
      w_load = 16'h0000;
    else if (r_byte)
      w_load = {8'h00, (w_lane ? w_word[15:8] : w_word[7:0])};
    else
      w_load = w_word;
  end

  // NOTE: every signal written in a combinational block gets a default
  // before any branching, otherwise synthesis infers a latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: if (req_valid) w_next_state = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
      S_WAIT: if (r_cnt == 4'd1) w_next_state = S_RESP;
      S_RESP: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Outputs are gated by reset so a request caught mid-flight produces no
  // response and no stall while reset is held.
  always_comb begin
    req_ready = (r_state == S_IDLE) && !reset;
    rsp_valid = w_in_resp && !reset;
    rsp_err   = w_in_resp && !reset && w_misaligned;
    rsp_rdata = w_in_resp ? w_load : r_rdata;
    // Low in RESP so the pipeline advances exactly once per request.
    stall     = !reset && (r_state != S_RESP) &&
                ((r_state != S_IDLE) || req_valid);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_write <= 1'b0;
      r_byte  <= 1'b0;
      r_addr  <= 16'h0000;
      r_wdata <= 16'h0000;
      r_rdata <= 16'h0000;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_write <= req_write;
        r_byte  <= req_byte;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_cnt   <= CNT_INIT;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_in_resp) r_rdata <= w_load;
    end
  end

  // NOTE: the array is cleared by reset because software relies on memory
  // reading zero after reset; this keeps it in flops rather than a RAM macro.
  // Stores commit on the edge leaving RESP; a reset during WAIT discards them.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) r_mem[i] <= 16'h0000;
    end else if (w_in_resp && r_write && !w_misaligned) begin
      if (r_byte) begin
        if (w_lane) r_mem[w_idx][15:8] <= r_wdata[7:0];
        else        r_mem[w_idx][7:0]  <= r_wdata[7:0];
      end else begin
        r_mem[w_idx] <= r_wdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Two instances: dut (WAIT_STATES=2) takes directed and random traffic that
// is checked against a byte-array memory model; dut0 (WAIT_STATES=0) takes a
// back-to-back burst with req_valid held high.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int WS = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WAIT_STATES=2 instance
  logic        rst, v, w, b;
  logic [15:0] a, wd;
  logic        rdy, rv, re, st;
  logic [15:0] rd;

  // WAIT_STATES=0 instance
  logic        rst0, v0, w0, b0;
  logic [15:0] a0, wd0;
  logic        rdy0, rv0, re0, st0;
  logic [15:0] rd0;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(WS)) dut (
    .clk(clk), .reset(rst), .req_valid(v), .req_write(w), .req_byte(b),
    .req_addr(a), .req_wdata(wd), .req_ready(rdy), .rsp_valid(rv),
    .rsp_rdata(rd), .rsp_err(re), .stall(st)
  );

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(rst0), .req_valid(v0), .req_write(w0), .req_byte(b0),
    .req_addr(a0), .req_wdata(wd0), .req_ready(rdy0), .rsp_valid(rv0),
    .rsp_rdata(rd0), .rsp_err(re0), .stall(st0)
  );

  int errors = 0;
  int checks = 0;

  // Reference memory: 512 bytes, little-endian, address taken modulo 512.
  logic [7:0]  mem2 [512];
  logic        hold_known;
  logic [15:0] last_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete request on the WAIT_STATES=2 instance.
  task automatic req2(input logic wr, input logic by, input logic [15:0] addr,
                      input logic [15:0] wdata);
    logic [8:0]  ba;
    logic [15:0] exp;
    logic        exp_err;
    logic        seen;
    logic [31:0] tmp;
    int          n;
    int          sc;
    ba      = addr[8:0];
    exp_err = !by && addr[0];
    if (exp_err)  exp = 16'h0000;
    else if (by)  exp = {8'h00, mem2[ba]};
    else          exp = {mem2[ba + 9'd1], mem2[ba]};

    @(negedge clk);
    if (hold_known) check("rdata_held", rd, last_rd);
    v = 1'b1; w = wr; b = by; a = addr; wd = wdata;
    #1;
    check("ready_idle", rdy, 1);
    check("stall_idle_req", st, 1);
    @(posedge clk);
    #1;
    // Scramble inputs: they must be ignored once the request is latched.
    tmp = $urandom;
    v = 1'b0; w = tmp[0]; b = tmp[1]; a = 16'($urandom); wd = 16'($urandom);

    sc = 1; n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (rv) seen = 1'b1;
      else begin
        if (st) sc++;
        check("ready_wait", rdy, 0);
      end
    end
    check("latency", n, WS + 1);
    check("stall_cycles", sc, WS + 1);
    check("stall_resp", st, 0);
    check("err", re, exp_err);
    if (!wr) check("rdata", rd, exp);

    if (wr && !exp_err) begin
      mem2[ba] = wdata[7:0];
      if (!by) mem2[ba + 9'd1] = wdata[15:8];
    end
    hold_known = !wr;
    last_rd    = exp;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic        r_wr   [4];
    logic        r_by   [4];
    logic [15:0] r_ad   [4];
    logic [15:0] r_wd   [4];
    logic [15:0] r_exp  [4];
    logic [31:0] tmp;
    int          pulses;

    for (int i = 0; i < 512; i++) mem2[i] = 8'h00;
    hold_known = 1'b1;
    last_rd    = 16'h0000;
    rst = 1'b1; v = 1'b0; w = 1'b0; b = 1'b0; a = '0; wd = '0;
    rst0 = 1'b1; v0 = 1'b0; w0 = 1'b0; b0 = 1'b0; a0 = '0; wd0 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; rst0 = 1'b0;
    #1;
    check("rst_ready", rdy, 1);
    check("rst_valid", rv, 0);
    check("rst_rdata", rd, 0);
    check("rst_err", re, 0);
    check("rst_stall", st, 0);
    check("rst_ready0", rdy0, 1);

    // Directed sequence.
    req2(1'b1, 1'b0, 16'h0010, 16'hBEEF);
    req2(1'b0, 1'b0, 16'h0010, 16'h0000);
    req2(1'b1, 1'b1, 16'h0011, 16'h005A);
    req2(1'b0, 1'b0, 16'h0010, 16'h0000);
    req2(1'b0, 1'b1, 16'h0011, 16'h0000);
    req2(1'b0, 1'b0, 16'h0003, 16'h0000);
    req2(1'b0, 1'b0, 16'h0002, 16'h0000);
    req2(1'b1, 1'b0, 16'h0005, 16'hFFFF);
    req2(1'b0, 1'b0, 16'h0004, 16'h0000);
    req2(1'b1, 1'b0, 16'h0204, 16'h1234);
    req2(1'b0, 1'b0, 16'h0004, 16'h0000);

    // Random traffic over a small window with random high bits to hit wrap.
    for (int k = 0; k < 60; k++) begin
      tmp = $urandom;
      req2(tmp[0], tmp[1],
           16'($urandom_range(0, 47)) | (16'($urandom) & 16'hFE00),
           16'($urandom));
    end

    // Zero wait states, req_valid held high for four requests.
    r_wr  = '{1'b1, 1'b0, 1'b1, 1'b0};
    r_by  = '{1'b0, 1'b0, 1'b1, 1'b0};
    r_ad  = '{16'h0040, 16'h0040, 16'h0041, 16'h0040};
    r_wd  = '{16'hCAFE, 16'h0000, 16'h0077, 16'h0000};
    r_exp = '{16'h0000, 16'hCAFE, 16'h0000, 16'h77FE};
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      v0 = 1'b1; w0 = r_wr[k]; b0 = r_by[k]; a0 = r_ad[k]; wd0 = r_wd[k];
      #1;
      check("ws0_ready_idle", rdy0, 1);
      check("ws0_stall_idle", st0, 1);
      check("ws0_valid_idle", rv0, 0);
      @(negedge clk);
      check("ws0_valid_resp", rv0, 1);
      check("ws0_stall_resp", st0, 0);
      check("ws0_ready_resp", rdy0, 0);
      check("ws0_err", re0, 0);
      if (!r_wr[k]) check("ws0_rdata", rd0, r_exp[k]);
    end
    v0 = 1'b0;

    // Reset during WAIT of a store: no response, write discarded.
    @(negedge clk);
    v = 1'b1; w = 1'b1; b = 1'b0; a = 16'h0020; wd = 16'hABCD;
    @(posedge clk);
    #1;
    v = 1'b0;
    @(negedge clk);
    check("abort_in_wait", rdy, 0);
    rst = 1'b1;
    #1;
    check("abort_stall_in_reset", st, 0);
    check("abort_valid_in_reset", rv, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_ready", rdy, 1);
    check("abort_rdata", rd, 0);
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (rv) pulses++;
    end
    check("abort_no_rsp", pulses, 0);
    for (int i = 0; i < 512; i++) mem2[i] = 8'h00;
    hold_known = 1'b1;
    last_rd    = 16'h0000;
    req2(1'b0, 1'b0, 16'h0020, 16'h0000);
    req2(1'b0, 1'b0, 16'h0010, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder that serves the CPU's M-stage load/store requests (word load, zero-extended byte load, word store, store-byte) through a valid/ready handshake.
- Configurable wait states are inserted before each response. A stall output freezes the pipeline until the access completes.
- Replaces the single-cycle data memory model so the pipeline can be exercised against realistic memory latency.

Parameters:
- DEPTH_WORDS, 256, number of 16-bit words stored; byte address space is 2*DEPTH_WORDS. Power of two, min 2.
- WAIT_STATES, 2, extra cycles between accept and response; legal range 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  CPU presents a memory request (memRead or memWrite set in M stage).
- req_write  input  1  1 = store, 0 = load.
- req_byte  input  1  1 = byte access (sb / zero-extended load byte), 0 = word access.
- req_addr  input  16  byte address.
- req_wdata  input  16  store data; byte store uses [7:0].
- req_ready  output  1  responder can accept a request this cycle.
- rsp_valid  output  1  one-cycle pulse: access complete, rsp_rdata/rsp_err valid.
- rsp_rdata  output  16  load data.
- rsp_err  output  1  misaligned word access flagged with the response.
- stall  output  1  freeze PC/IFID/IDEX/EXM; MWB receives a bubble.

Behaviour:
- Storage and addressing:
  - Little-endian byte-addressed array of DEPTH_WORDS words.
  - Word index = req_addr[log2(DEPTH_WORDS):1]. Higher address bits are ignored, so addresses wrap modulo 2*DEPTH_WORDS.
  - Byte lane is selected by req_addr[0]: 0 selects [7:0], 1 selects [15:8].
- Reset (synchronous, active-high):
  - FSM goes to IDLE; the wait counter, latched request and all output registers clear.
  - All memory words clear to 16'h0000.
  - A request in flight is aborted and its write is discarded.
  - Outputs during and after reset: req_ready=1 once reset deasserts; rsp_valid=0, rsp_rdata=0, rsp_err=0. stall=0 while reset is high.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On a clock edge with req_valid=1, latch write/byte/addr/wdata and load cnt=WAIT_STATES.
  - Next state is WAIT if WAIT_STATES>0, otherwise RESP.
- WAIT:
  - req_ready=0; cnt decrements each cycle.
  - When cnt==1 at the edge, go to RESP.
- RESP:
  - rsp_valid=1 for exactly this one cycle; req_ready=0.
  - Next state is always IDLE. Back-to-back requests therefore see at least one IDLE cycle between accepts.
- Latency: rsp_valid rises exactly WAIT_STATES+1 cycles after the accepting edge.
- Memory commit:
  - Stores commit on the edge that leaves RESP.
  - A load is evaluated combinationally from memory in RESP, so a load following a store to the same address sees the new data.
- stall = (state!=RESP) && (state!=IDLE || req_valid). stall is 0 in the RESP cycle so the pipeline advances exactly once per request.
- Load data:
  - Word load: rsp_rdata = full word.
  - Byte load: rsp_rdata = {8'h00, selected byte}.
  - rsp_rdata is held at its last value outside RESP.
- Stores:
  - Word store writes all 16 bits.
  - Byte store writes only the selected lane with req_wdata[7:0]; the other lane is unchanged.
- Misaligned access (word access with req_addr[0]=1):
  - No memory write; rsp_rdata=16'h0000; rsp_err=1 for the RESP cycle. Timing is otherwise identical.
  - rsp_err=0 for all other responses.
- req_valid deasserted while in WAIT/RESP is ignored; the latched request completes.
- req_* inputs are only sampled in IDLE.

Test Plan:
- WAIT_STATES=2: word store 16'hBEEF to addr 16'h0010, then word load from 16'h0010 -> each rsp_valid comes 3 cycles after accept; load returns 16'hBEEF with rsp_err=0; stall high 3 cycles per request.
- Byte store 8'h5A to addr 16'h0011 over existing 16'hBEEF, then word load 16'h0010 -> 16'h5AEF. Byte load from 16'h0011 -> 16'h005A.
- Word load from misaligned addr 16'h0003 -> rsp_rdata=0 and rsp_err=1. A following word load from 16'h0002 shows the contents unchanged.
- WAIT_STATES=0: req_valid held high for 4 requests -> rsp_valid 1 cycle after each accept; accepts on alternating cycles; stall=0 in every RESP cycle.
- Assert reset during WAIT of a store to 16'h0020 -> no rsp_valid; state IDLE with req_ready=1 after release; a load from 16'h0020 returns 16'h0000.
- DEPTH_WORDS=256: store 16'h1234 to addr 16'h0204, then load from 16'h0004 -> 16'h1234 (address wrap).
